// File: rtl/cen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cen_pkg
//  Purpose  : Shared widths, named divide ratios and the parameter-slicing
//             helper for the fractional clock-enable generator.
//  Revision : 1.0 - initial release
// ============================================================================
package cen_pkg;

    localparam int CEN_ACC_W  = 16;
    localparam int CEN_MAX_CH = 8;
    localparam int CEN_MAX_W  = 32;
    localparam int CEN_VEC_W  = CEN_MAX_CH * CEN_MAX_W;

    typedef struct packed {
        logic [CEN_ACC_W-1:0] num;
        logic [CEN_ACC_W-1:0] den;
    } cen_ratio_t;

    // Ratios against the 80 MHz system clock
    localparam cen_ratio_t CEN_68K_8M = '{num: 16'd1, den: 16'd10};
    localparam cen_ratio_t CEN_Z80_4M = '{num: 16'd1, den: 16'd20};
    localparam cen_ratio_t CEN_YM_4M  = '{num: 16'd1, den: 16'd20};

    function automatic logic [CEN_MAX_W-1:0] ch_slice(
        input logic [CEN_VEC_W-1:0] vec,
        input int                   idx,
        input int                   width
    );
        logic [CEN_VEC_W-1:0] shifted;
        shifted = vec >> (idx * width);
        return shifted[CEN_MAX_W-1:0] & CEN_MAX_W'((64'd1 << width) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cen_frac_gen_ch.sv
`default_nettype none
// ============================================================================
//  Module   : cen_frac_ch
//  Purpose  : One fractional enable channel: accumulator, cen/cen_b phase,
//             pause hold and resync restart.
//  Revision : 1.0 - initial release
// ============================================================================
module cen_frac_ch #(
    parameter int               ACC_W = 16,
    parameter logic [ACC_W-1:0] NUM   = 1,
    parameter logic [ACC_W-1:0] DEN   = 10
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_resync,
    input  logic i_pause,
    output logic o_cen,
    output logic o_cen_b
);

    localparam int SUM_W = ACC_W + 2;
    localparam logic [SUM_W-1:0] c_step = SUM_W'(NUM) << 1;
    localparam logic [SUM_W-1:0] c_den  = SUM_W'(DEN);

    if (NUM == '0 || c_step > c_den) begin : g_bad_ratio
        $error("cen_frac_ch: illegal ratio, need NUM>0 and 2*NUM<=DEN");
    end

    logic [ACC_W-1:0] r_acc;
    logic             r_phase;
    logic             r_cen;
    logic             r_cen_b;
    logic [SUM_W-1:0] w_sum;
    logic             w_cross;

    always_comb begin
        w_sum   = SUM_W'(r_acc) + c_step;
        w_cross = (w_sum >= c_den);
    end

    // acc < DEN and 2*NUM <= DEN, so one subtraction always brings acc back below DEN
    always_ff @(posedge clk_sys) begin
        if (!rst_n || !i_run || i_resync) begin
            r_acc   <= '0;
            r_phase <= 1'b0;
            r_cen   <= 1'b0;
            r_cen_b <= 1'b0;
        end else if (i_pause) begin
            r_cen   <= 1'b0;
            r_cen_b <= 1'b0;
        end else begin
            r_cen   <= w_cross & ~r_phase;
            r_cen_b <= w_cross &  r_phase;
            if (w_cross) begin
                r_acc   <= ACC_W'(w_sum - c_den);
                r_phase <= ~r_phase;
            end else begin
                r_acc   <= ACC_W'(w_sum);
            end
        end
    end

    assign o_cen   = r_cen;
    assign o_cen_b = r_cen_b;

endmodule
`default_nettype wire

// File: rtl/cen_frac_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cen_frac_gen
//  Purpose  : Multi-channel fractional cen/cen_b generator, gated until the
//             PLL lock has been stable for LOCK_HOLD cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module cen_frac_gen
    import cen_pkg::*;
#(
    parameter int                      NUM_CH    = 2,
    parameter int                      ACC_W     = CEN_ACC_W,
    parameter logic [NUM_CH*ACC_W-1:0] CH_NUM    = {CEN_Z80_4M.num, CEN_68K_8M.num},
    parameter logic [NUM_CH*ACC_W-1:0] CH_DEN    = {CEN_Z80_4M.den, CEN_68K_8M.den},
    parameter int                      LOCK_HOLD = 1024
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              pll_locked,
    input  logic              resync,
    input  logic [NUM_CH-1:0] pause,
    output logic              ready,
    output logic [NUM_CH-1:0] cen,
    output logic [NUM_CH-1:0] cen_b
);

    if (NUM_CH < 1 || NUM_CH > CEN_MAX_CH || ACC_W < 2 || ACC_W > CEN_MAX_W
        || LOCK_HOLD < 1) begin : g_bad_cfg
        $error("cen_frac_gen: unsupported NUM_CH / ACC_W / LOCK_HOLD");
    end

    localparam int c_hold_w = $clog2(LOCK_HOLD + 1);
    localparam logic [c_hold_w-1:0] c_hold = c_hold_w'(LOCK_HOLD);

    logic                r_lock_meta;
    logic                r_lock_sync;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                w_run;

    // pll_locked is asynchronous to clk_sys
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
            r_hold_cnt  <= '0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_sync <= r_lock_meta;
            if (!r_lock_sync) begin
                r_hold_cnt <= '0;
            end else if (r_hold_cnt != c_hold) begin
                r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
            end
        end
    end

    assign ready = (r_hold_cnt == c_hold);
    // Channels drop to reset as soon as the synced lock falls, together with ready
    assign w_run = ready & r_lock_sync;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [ACC_W-1:0] c_num = ACC_W'(ch_slice(CEN_VEC_W'(CH_NUM), g, ACC_W));
        localparam logic [ACC_W-1:0] c_den = ACC_W'(ch_slice(CEN_VEC_W'(CH_DEN), g, ACC_W));

        cen_frac_ch #(
            .ACC_W (ACC_W),
            .NUM   (c_num),
            .DEN   (c_den)
        ) u_ch (
            .clk_sys  (clk_sys),
            .rst_n    (rst_n),
            .i_run    (w_run),
            .i_resync (resync),
            .i_pause  (pause[g]),
            .o_cen    (cen[g]),
            .o_cen_b  (cen_b[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_cen_frac_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cen_frac_gen
//  Purpose  : Self-checking bench for cen_frac_gen (scoreboard of per-cycle
//             expected outputs plus a fractional-ratio statistics run).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cen_frac_gen;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       pll_locked;
    logic       resync;
    logic [1:0] pause;
    logic       ready;
    logic [1:0] cen;
    logic [1:0] cen_b;

    logic       rst2_n;
    logic       locked2 = 1'b1;
    logic       resync2 = 1'b0;
    logic [0:0] pause2  = 1'b0;
    logic       ready2;
    logic [0:0] cen2;
    logic [0:0] cen2_b;

    always #5 clk_sys = ~clk_sys;

    cen_frac_gen #(
        .NUM_CH    (2),
        .ACC_W     (16),
        .CH_NUM    ({16'd1, 16'd1}),
        .CH_DEN    ({16'd20, 16'd10}),
        .LOCK_HOLD (1024)
    ) u_dut (
        .clk_sys    (clk_sys),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .resync     (resync),
        .pause      (pause),
        .ready      (ready),
        .cen        (cen),
        .cen_b      (cen_b)
    );

    cen_frac_gen #(
        .NUM_CH    (1),
        .ACC_W     (16),
        .CH_NUM    (16'd3),
        .CH_DEN    (16'd70),
        .LOCK_HOLD (8)
    ) u_dut2 (
        .clk_sys    (clk_sys),
        .rst_n      (rst2_n),
        .pll_locked (locked2),
        .resync     (resync2),
        .pause      (pause2),
        .ready      (ready2),
        .cen        (cen2),
        .cen_b      (cen2_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk_sys) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic       rdy;
        logic [1:0] cen;
        logic [1:0] cen_b;
        string      name;
    } exp_t;

    typedef struct {
        string      name;
        int         off;
        logic [1:0] cen;
        logic [1:0] cen_b;
    } vec_t;

    exp_t sb_q[$];
    exp_t sb_e;
    vec_t vecs[12];

    // Scoreboard: pop every entry due by this cycle and compare against the DUT
    always @(negedge clk_sys) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            sb_e = sb_q.pop_front();
            n_tests++;
            if (sb_e.cyc != cyc || ready !== sb_e.rdy || cen !== sb_e.cen || cen_b !== sb_e.cen_b) begin
                n_fail++;
                $display("FAIL %s cyc=%0d(due %0d): got ready=%b cen=%b cen_b=%b, want ready=%b cen=%b cen_b=%b",
                         sb_e.name, cyc, sb_e.cyc, ready, cen, cen_b, sb_e.rdy, sb_e.cen, sb_e.cen_b);
            end
        end
    end

    // Reference timing: anchors are the cycles where each accumulator sat at zero
    int a0, a1;
    int plo = -1;
    int phi = -2;

    // Integer ratio: pulses every 'half' cycles after the anchor, alternating cen then cen_b
    function automatic logic [1:0] ph(input int off, input int half);
        if (off <= 0 || (off % half) != 0) return 2'b00;
        return (((off / half) % 2) == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic push_exp(input int c, input logic r, input logic [1:0] ce,
                            input logic [1:0] cb, input string nm);
        exp_t e;
        e.cyc = c; e.rdy = r; e.cen = ce; e.cen_b = cb; e.name = nm;
        sb_q.push_back(e);
    endtask

    task automatic push_idle(input int lo, input int hi, input string nm);
        for (int c = lo; c <= hi; c++) push_exp(c, 1'b0, 2'b00, 2'b00, nm);
    endtask

    task automatic push_run(input int lo, input int hi, input string nm);
        logic [1:0] v0, v1;
        int         off0;
        for (int c = lo; c <= hi; c++) begin
            off0 = c - a0;
            if (phi >= plo && c > phi) off0 -= (phi - plo + 1);
            v0 = (c >= plo && c <= phi) ? 2'b00 : ph(off0, 5);
            v1 = ph(c - a1, 10);
            push_exp(c, 1'b1, {v1[0], v0[0]}, {v1[1], v0[1]}, nm);
        end
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk_sys);
    endtask

    task automatic set_vec(input int i, input string nm, input int off,
                           input logic [1:0] ce, input logic [1:0] cb);
        vecs[i].name = nm; vecs[i].off = off; vecs[i].cen = ce; vecs[i].cen_b = cb;
    endtask

    int t0, c, k;
    int nc, nb, last, gap_bad, alt_bad;
    logic exp_b;

    initial begin
        set_vec(0,  "s1_off4",    4, 2'b00, 2'b00);
        set_vec(1,  "s1_cen0_1",  5, 2'b01, 2'b00);
        set_vec(2,  "s1_off6",    6, 2'b00, 2'b00);
        set_vec(3,  "s1_b0_c1",  10, 2'b10, 2'b01);
        set_vec(4,  "s1_off14",  14, 2'b00, 2'b00);
        set_vec(5,  "s1_cen0_2", 15, 2'b01, 2'b00);
        set_vec(6,  "s1_b0_b1",  20, 2'b00, 2'b11);
        set_vec(7,  "s1_cen0_3", 25, 2'b01, 2'b00);
        set_vec(8,  "s1_b0_c1b", 30, 2'b10, 2'b01);
        set_vec(9,  "s1_cen0_4", 35, 2'b01, 2'b00);
        set_vec(10, "s1_b0_b1b", 40, 2'b00, 2'b11);
        set_vec(11, "s1_cen0_5", 45, 2'b01, 2'b00);

        rst_n = 1'b0; rst2_n = 1'b0; pll_locked = 1'b1; resync = 1'b0; pause = 2'b00;

        // 1: reset, lock qualification, steady pulse trains
        push_idle(1, 2, "reset");
        wait_to(2);
        rst_n = 1'b1;
        t0 = 2;
        push_idle(t0 + 1, t0 + 1025, "lock_wait");
        a0 = t0 + 1026; a1 = a0;
        push_exp(a0, 1'b1, 2'b00, 2'b00, "ready_rise");
        for (int i = 0; i < 12; i++)
            push_exp(a0 + vecs[i].off, 1'b1, vecs[i].cen, vecs[i].cen_b, vecs[i].name);
        push_run(a0 + 46, a0 + 120, "s1_run");
        wait_to(a0 + 120);

        // 3: pause ch0 for 37 cycles
        c = cyc;
        plo = c + 1; phi = c + 37;
        push_run(c + 1, c + 100, "s3_pause");
        pause = 2'b01;
        wait_to(c + 37);
        pause = 2'b00;
        wait_to(c + 100);
        a0 += 37; plo = -1; phi = -2;

        // 4: resync on a cycle where ch0 would otherwise pulse
        while (((cyc + 1 - a0) % 5) != 0) @(negedge clk_sys);
        c = cyc;
        a0 = c + 1; a1 = c + 1;
        push_run(c + 1, c + 60, "s4_resync");
        resync = 1'b1;
        @(negedge clk_sys);
        resync = 1'b0;
        wait_to(c + 60);

        // 5: one-cycle lock glitch forces full requalification
        c = cyc;
        push_run(c + 1, c + 2, "s5_pre");
        push_idle(c + 3, c + 1026, "s5_requal");
        pll_locked = 1'b0;
        @(negedge clk_sys);
        pll_locked = 1'b1;
        a0 = c + 1027; a1 = a0;
        push_run(a0, a0 + 45, "s5_run");
        wait_to(a0 + 45);

        // 6: reset in the middle of the pulse train
        while (((cyc + 1 - a0) % 5) != 0) @(negedge clk_sys);
        c = cyc;
        push_idle(c + 1, c + 1026, "s6_reset");
        rst_n = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        a0 = c + 1027; a1 = a0;
        push_run(a0, a0 + 45, "s6_run");
        wait_to(a0 + 45);

        // 2: NUM=3, DEN=70 statistics on the second instance
        rst2_n = 1'b1;
        k = 0;
        while (ready2 !== 1'b1 && k < 100) begin
            @(negedge clk_sys);
            k++;
        end
        n_tests++;
        if (ready2 !== 1'b1) begin
            n_fail++;
            $display("FAIL s2_ready: got ready=%b after %0d cycles, want 1", ready2, k);
        end
        nc = 0; nb = 0; last = 0; gap_bad = 0; alt_bad = 0; exp_b = 1'b0;
        for (int i = 1; i <= 7000; i++) begin
            @(negedge clk_sys);
            if (cen2[0] === 1'b1 && cen2_b[0] === 1'b1) begin
                alt_bad++;
            end else if (cen2[0] === 1'b1 || cen2_b[0] === 1'b1) begin
                if (cen2_b[0] !== exp_b) alt_bad++;
                exp_b = ~cen2_b[0];
                if (cen2[0] === 1'b1) nc++; else nb++;
                if ((i - last) != 11 && (i - last) != 12) gap_bad++;
                last = i;
            end
        end
        n_tests++;
        if (nc != 300) begin
            n_fail++;
            $display("FAIL s2_cen_count: got %0d, want 300", nc);
        end
        n_tests++;
        if (nb != 300) begin
            n_fail++;
            $display("FAIL s2_cen_b_count: got %0d, want 300", nb);
        end
        n_tests++;
        if (gap_bad != 0) begin
            n_fail++;
            $display("FAIL s2_gaps: got %0d gaps outside 11..12, want 0", gap_bad);
        end
        n_tests++;
        if (alt_bad != 0) begin
            n_fail++;
            $display("FAIL s2_alternate: got %0d overlap/order errors, want 0", alt_bad);
        end

        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
